// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with runtime cpol/cpha/bit order and NUM_CS decoded selects; define SPI_LOOPBACK_EN to sample mosi instead of miso.
// Latency: done pulses (2*DATA_W+2)*CLK_DIV clk cycles after the accepting edge; dout updates on that same edge.
// Backpressure: ready is high only in IDLE; newd is ignored in every other state (a request on the done cycle is accepted).
module spi_master_multi #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10,
    parameter int NUM_CS  = 1,
    localparam int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TG_W  = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TG_W-1:0]  TG_LAST  = TG_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [TG_W-1:0]   tcnt;
    logic [DATA_W-1:0] txr;
    logic [DATA_W-1:0] rxr;
    logic              l_cpha;
    logic              l_lsb;

    logic              div_end;
    logic              lead_edge;
    logic              last_edge;
    logic              samp_bit;
    logic              out_cur;
    logic              out_nxt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [NUM_CS-1:0] cs_dec;

`ifdef SPI_LOOPBACK_EN
    logic miso_unused;
    assign miso_unused = miso;
    assign samp_bit    = mosi;
`else
    assign samp_bit    = miso;
`endif

    always_comb begin
        div_end   = (div == DIV_LAST);
        // Even toggle count means the next sclk toggle is a leading edge.
        lead_edge = ~tcnt[0];
        last_edge = (tcnt == TG_LAST);
        tx_shift  = l_lsb ? {1'b0, txr[DATA_W-1:1]} : {txr[DATA_W-2:0], 1'b0};
        out_cur   = l_lsb ? txr[0] : txr[DATA_W-1];
        out_nxt   = l_lsb ? txr[1] : txr[DATA_W-2];
        rx_next   = l_lsb ? {samp_bit, rxr[DATA_W-1:1]} : {rxr[DATA_W-2:0], samp_bit};
        // An out-of-range index matches no bit, leaving every select high.
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (int'(cs_sel) != i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div    <= '0;
            tcnt   <= '0;
            txr    <= '0;
            rxr    <= '0;
            l_cpha <= 1'b0;
            l_lsb  <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= '1;
            ready  <= 1'b1;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (newd) begin
                        state  <= LEAD;
                        ready  <= 1'b0;
                        div    <= '0;
                        tcnt   <= '0;
                        txr    <= din;
                        rxr    <= '0;
                        l_cpha <= cpha;
                        l_lsb  <= lsb_first;
                        cs_n   <= cs_dec;
                        mosi   <= cpha ? 1'b0 : (lsb_first ? din[0] : din[DATA_W-1]);
                    end
                end
                LEAD: begin
                    if (div_end) begin
                        div   <= '0;
                        state <= XFER;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                XFER: begin
                    if (div_end) begin
                        div  <= '0;
                        sclk <= ~sclk;
                        tcnt <= tcnt + TG_W'(1);
                        // cpha=0 samples on leading edges, cpha=1 on trailing edges.
                        if (lead_edge != l_cpha) begin
                            rxr <= rx_next;
                        end
                        if (l_cpha && lead_edge) begin
                            mosi <= out_cur;
                            txr  <= tx_shift;
                        end else if (!l_cpha && !lead_edge && !last_edge) begin
                            mosi <= out_nxt;
                            txr  <= tx_shift;
                        end
                        if (last_edge) begin
                            state <= TRAIL;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                TRAIL: begin
                    if (div_end) begin
                        state <= IDLE;
                        div   <= '0;
                        cs_n  <= '1;
                        dout  <= rxr;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        mosi  <= 1'b0;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an 8-bit/4-select/div-2 instance and a 12-bit/3-select/div-3 instance.
module tb_spi_master_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, newd, cpol, cpha, lsb_first, miso;
    logic [11:0] din;
    logic [1:0]  cs_sel;
    int          sel;

    logic       a_ready, a_done, a_sclk, a_mosi;
    logic [7:0] a_dout;
    logic [3:0] a_csn;

    logic        b_ready, b_done, b_sclk, b_mosi;
    logic [11:0] b_dout;
    logic [2:0]  b_csn;

    logic        v_ready, v_done, v_sclk, v_mosi;
    logic [11:0] v_dout;
    logic [3:0]  v_csn;

    int checks   = 0;
    int failures = 0;

    spi_master_multi #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_a (
        .clk(clk), .rst(rst), .newd(newd && (sel == 0)), .din(din[7:0]), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
        .ready(a_ready), .done(a_done), .dout(a_dout), .sclk(a_sclk), .mosi(a_mosi), .cs_n(a_csn)
    );

    spi_master_multi #(.DATA_W(12), .CLK_DIV(3), .NUM_CS(3)) u_b (
        .clk(clk), .rst(rst), .newd(newd && (sel == 1)), .din(din), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
        .ready(b_ready), .done(b_done), .dout(b_dout), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_csn)
    );

    always_comb begin
        if (sel == 0) begin
            v_ready = a_ready; v_done = a_done; v_sclk = a_sclk; v_mosi = a_mosi;
            v_dout  = {4'h0, a_dout};
            v_csn   = a_csn;
        end else begin
            v_ready = b_ready; v_done = b_done; v_sclk = b_sclk; v_mosi = b_mosi;
            v_dout  = b_dout;
            v_csn   = {1'b1, b_csn};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_rx(input logic [11:0] d, input logic [11:0] s);
`ifdef SPI_LOOPBACK_EN
        return d;
`else
        return s;
`endif
    endfunction

    task automatic idle_watch(input string tag, input int ncyc);
        int nd = 0;
        int nr = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (v_done)   nd++;
            if (!v_ready) nr++;
        end
        check({tag, "/no_done"}, nd, 0);
        check({tag, "/ready_held"}, nr, 0);
    endtask

    // Called at a negedge; the slave answers with spat in the same bit order, sampled on rising sclk.
    task automatic xfer(input string tag, input logic [11:0] d, input logic [11:0] spat,
                        input logic [1:0] cs, input logic m_cpol, input logic m_cpha, input logic m_lsb,
                        input logic [3:0] e_csn, input logic [11:0] e_mosi,
                        input int rst_at, input int poke_at);
        int n, dv, cyc, rises;
        logic [11:0] cap, d0;
        logic prev, dchg, seen_done;
        n  = (sel == 0) ? 8 : 12;
        dv = (sel == 0) ? 2 : 3;
        d0 = v_dout;
        din = d; cs_sel = cs; cpol = m_cpol; cpha = m_cpha; lsb_first = m_lsb;
        newd = 1'b1;
        miso = m_lsb ? spat[0] : spat[n-1];
        @(negedge clk);
        newd = 1'b0;
        check({tag, "/accept_ready"}, v_ready, 0);
        check({tag, "/accept_done"}, v_done, 0);
        check({tag, "/accept_sclk"}, v_sclk, m_cpol);
        cyc = 0; rises = 0; cap = '0; prev = v_sclk; dchg = 1'b0; seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (v_sclk && !prev) begin
                cap = {cap[10:0], v_mosi};
                rises++;
            end
            prev = v_sclk;
            miso = (rises >= n) ? 1'b0 : (m_lsb ? spat[rises] : spat[n-1-rises]);
            if (v_done) seen_done = 1'b1;
            else if (v_dout !== d0) dchg = 1'b1;
            if (cyc == 10) begin
                check({tag, "/csn_mid"}, v_csn, e_csn);
                check({tag, "/ready_mid"}, v_ready, 0);
            end
            if (cyc == poke_at) begin
                din  = 12'h555;
                newd = 1'b1;
            end else if (cyc == poke_at + 1) begin
                newd = 1'b0;
            end
            if (cyc == rst_at) rst = 1'b1;
            if (cyc == rst_at + 1) begin
                rst = 1'b0;
                check({tag, "/csn"}, v_csn, 4'hF);
                check({tag, "/ready"}, v_ready, 1);
                check({tag, "/done"}, v_done, 0);
                check({tag, "/dout"}, v_dout, 12'h000);
                check({tag, "/sclk"}, v_sclk, 0);
                check({tag, "/mosi"}, v_mosi, 0);
                idle_watch(tag, 100);
                return;
            end
        end
        check({tag, "/done_seen"}, seen_done, 1);
        check({tag, "/done_cycle"}, cyc, (2 * n + 2) * dv);
        check({tag, "/rises"}, rises, n);
        check({tag, "/mosi_bits"}, cap, e_mosi);
        check({tag, "/dout"}, v_dout, exp_rx(d, spat));
        check({tag, "/dout_hold"}, dchg, 0);
        check({tag, "/csn_end"}, v_csn, 4'hF);
        check({tag, "/ready_end"}, v_ready, 1);
        check({tag, "/mosi_end"}, v_mosi, 0);
        check({tag, "/sclk_end"}, v_sclk, m_cpol);
    endtask

    initial begin
        rst = 1'b1; newd = 1'b0; din = '0; cs_sel = '0;
        cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; miso = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst/a_ready", a_ready, 1);
        check("rst/a_done", a_done, 0);
        check("rst/a_dout", a_dout, 8'h00);
        check("rst/a_csn", a_csn, 4'hF);
        check("rst/a_sclk", a_sclk, 0);
        check("rst/a_mosi", a_mosi, 0);
        check("rst/b_csn", b_csn, 3'h7);
        check("rst/b_dout", b_dout, 12'h000);
        check("rst/b_ready", b_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("idle/sclk_follows_cpol1", a_sclk, 1);
        cpol = 1'b0;
        @(negedge clk);
        check("idle/sclk_follows_cpol0", a_sclk, 0);

        // 8-bit: mode 0 MSB-first, then a back-to-back mode 3 transfer issued on the done cycle.
        xfer("a_m0", 12'h0A5, 12'h03C, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1110, 12'h0A5, -1, -1);
        xfer("a_b2b_m3", 12'h05A, 12'h0C3, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1011, 12'h05A, -1, -1);

        @(negedge clk);
        sel = 1;
        @(negedge clk);
        xfer("b_rst", 12'h0FF, 12'h000, 2'd2, 1'b0, 1'b0, 1'b0, 4'b1011, 12'h000, 10, -1);
        @(negedge clk);
        xfer("b_m3_lsb", 12'h0F1, 12'h6D2, 2'd1, 1'b1, 1'b1, 1'b1, 4'b1101, 12'h8F0, -1, -1);
        @(negedge clk);
        xfer("b_cs_oor", 12'h123, 12'hFED, 2'd3, 1'b0, 1'b0, 1'b0, 4'hF, 12'h123, -1, -1);
        @(negedge clk);
        xfer("b_poke", 12'h2C7, 12'h081, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1110, 12'hE34, -1, 20);
        idle_watch("b_poke_after", 100);
        check("b_poke/dout_final", v_dout, exp_rx(12'h2C7, 12'h081));
        @(negedge clk);
        xfer("b_lpbk", 12'hABC, 12'h35A, 2'd1, 1'b0, 1'b0, 1'b0, 4'b1101, 12'hABC, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
